// File: rtl/arb_sumador.sv
// arb_sumador: round-robin arbiter sharing one registered 8-bit adder among
// N requesters. Results appear two cycles after acceptance.
// Build option: define ARB_SUMADOR_CHAIN_EN to enable multi-byte chained
// bursts (ARB/WAIT/CHAIN FSM, owner lock, saved carry). Without it every
// operation is a single byte and rsp_last_o reads 1.
module arb_sumador #(
   parameter int N = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req_valid_i,
   output logic [N-1:0]     req_ready_o,
   input  logic [8*N-1:0]   req_a_i,
   input  logic [8*N-1:0]   req_b_i,
   input  logic [N-1:0]     req_c_i,
   input  logic [N-1:0]     req_last_i,
   output logic [N-1:0]     rsp_valid_o,
   output logic [7:0]       rsp_res_o,
   output logic             rsp_c_o,
   output logic             rsp_last_o,
   output logic             busy_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic          rr_found;
   logic [PW-1:0] rr_idx;
   logic          acc;
   logic [PW-1:0] gnt_idx;
   logic          cin_sel;
   logic          in_arb;

   // input stage / output stage of the adder, plus the in-flight tag pipe
   logic [7:0]    a_q, b_q;
   logic          c_q;
   logic [2:1]    vld_pipe;
   logic [PW-1:0] own1_q, own2_q;
   logic [7:0]    res_q;
   logic          co_q;
   logic [8:0]    sum;

`ifdef ARB_SUMADOR_CHAIN_EN
   typedef enum logic [1:0] {ARB, WAIT, CHAIN} state_t;
   state_t        state_q;
   logic [PW-1:0] owner_q;
   logic          saved_c_q;
   logic          last1_q, last2_q;
   logic          last_sel;
   assign in_arb = (state_q == ARB);
`else
   logic          last_tie_q;
   logic [N-1:0]  unused_last;
   assign in_arb      = 1'b1;
   assign unused_last = req_last_i;
`endif

   // first valid requester at or after the priority pointer
   always_comb begin
      int idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N) idx = idx - N;
         if (!rr_found && req_valid_i[idx]) begin
            rr_found = 1'b1;
            rr_idx   = PW'(idx);
         end
      end
   end

   // grant selection: round-robin in ARB, owner-only in CHAIN, none in WAIT
   always_comb begin
      acc     = 1'b0;
      gnt_idx = rr_idx;
      if (rst_ni) begin
`ifdef ARB_SUMADOR_CHAIN_EN
         case (state_q)
            ARB: acc = rr_found;
            CHAIN: begin
               gnt_idx = owner_q;
               acc     = req_valid_i[owner_q];
            end
            default: acc = 1'b0;
         endcase
`else
         acc = rr_found;
`endif
      end
   end

   assign req_ready_o = acc ? (N'(1) << gnt_idx) : '0;

`ifdef ARB_SUMADOR_CHAIN_EN
   assign last_sel = req_last_i[gnt_idx];
   // inside a burst the carry comes from the owner's previous byte
   assign cin_sel  = (state_q == CHAIN) ? saved_c_q : req_c_i[gnt_idx];
`else
   assign cin_sel  = req_c_i[gnt_idx];
`endif

   assign sum = {1'b0, a_q} + {1'b0, b_q} + {8'd0, c_q};

   // priority pointer advances past the winner on every ARB acceptance
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         ptr_q <= '0;
      else if (acc && in_arb)
         ptr_q <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
   end

   // adder datapath and tag pipeline; idle cycles shift in a zero tag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         vld_pipe <= '0;
         own1_q   <= '0;
         own2_q   <= '0;
         res_q    <= '0;
         co_q     <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[1], acc};
         if (acc) begin
            a_q    <= req_a_i[int'(gnt_idx)*8 +: 8];
            b_q    <= req_b_i[int'(gnt_idx)*8 +: 8];
            c_q    <= cin_sel;
            own1_q <= gnt_idx;
         end
         if (vld_pipe[1]) begin
            res_q  <= sum[7:0];
            co_q   <= sum[8];
            own2_q <= own1_q;
         end
      end
   end

`ifdef ARB_SUMADOR_CHAIN_EN
   // burst FSM; WAIT is the one cycle the previous byte spends in the adder,
   // so its carry-out is captured there and held for the rest of the burst
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ARB;
         owner_q   <= '0;
         saved_c_q <= 1'b0;
         last1_q   <= 1'b0;
         last2_q   <= 1'b0;
      end else begin
         if (acc) last1_q <= last_sel;
         if (vld_pipe[1]) last2_q <= last1_q;
         case (state_q)
            ARB: if (acc && !last_sel) begin
               owner_q <= gnt_idx;
               state_q <= WAIT;
            end
            WAIT: begin
               saved_c_q <= sum[8];
               state_q   <= CHAIN;
            end
            CHAIN: if (acc) state_q <= last_sel ? ARB : WAIT;
            default: state_q <= ARB;
         endcase
      end
   end

   assign rsp_last_o = last2_q;
   assign busy_o     = (state_q != ARB) | (|vld_pipe);
`else
   // reads 0 only while reset holds it down; every response sees 1
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_tie_q <= 1'b0;
      else         last_tie_q <= 1'b1;
   end

   assign rsp_last_o = last_tie_q;
   assign busy_o     = |vld_pipe;
`endif

   assign rsp_valid_o = vld_pipe[2] ? (N'(1) << own2_q) : '0;
   assign rsp_res_o   = res_q;
   assign rsp_c_o     = co_q;

endmodule
